can_bit_destuffer: RTL and testbench
====================================

Name: can_bit_destuffer

Overview:
- Downstream of the sync unit; receives its synchronized bus bit, sample one-shot and gated CAN bit clock.
- Performs bus integration (idle detect), start-of-frame (SOF) detection, CAN bit destuffing and stuff-error detection.
- Delivers one destuffed bit per valid strobe to the frame parser.

Parameters:
- STUFF_LEN, 5, number of identical consecutive bits after which a stuff bit is expected.
- IDLE_BITS, 11, number of consecutive recessive bits that declare the bus idle.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- canClk  in  1  gated CAN bit clock from the sync unit; a rising edge marks a bit-period boundary.
- sampleBit  in  1  synchronized bus level; 1 = recessive, 0 = dominant.
- samplePulse  in  1  single-cycle sample strobe from the sync unit.
- multiSelect  in  1  three samples per bit are in use; ignored unless CAN_MULTISAMPLE_EN is defined.
- destuffEn  in  1  from the frame parser; drive low from the CRC delimiter onward, which disables stuff checking.
- bitOut  out  1  destuffed bit value.
- bitValid  out  1  single-cycle strobe qualifying bitOut.
- sofPulse  out  1  single-cycle pulse, coincident with the bitValid of the SOF bit.
- stuffErr  out  1  single-cycle pulse on a stuff violation.
- busIdle  out  1  level; high while waiting for SOF.

Behaviour:
- Reset: async assert; state = INTEGRATE; all outputs 0; run counter = 0; recessive counter = 0.
- Bit decision: each sample pulse yields one decided bit. Without the macro, every samplePulse is a decided bit. All outputs are registered, so latency is 1 clk from the deciding samplePulse to bitValid, sofPulse or stuffErr.
- INTEGRATE:
  - Count consecutive recessive decided bits; a dominant bit clears the count.
  - Count reaches IDLE_BITS -> WAIT_SOF; busIdle = 1 from the next cycle.
  - No bitValid is emitted in this state.
- WAIT_SOF:
  - A dominant decided bit -> RX.
  - Emit bitValid = 1, bitOut = 0 and sofPulse = 1.
  - Set busIdle = 0, run value = 0, run count = 1.
- RX, destuffEn = 1:
  - Run count < STUFF_LEN: emit the bit. If it equals the run value, increment the count (saturating at STUFF_LEN); otherwise run value = bit and count = 1.
  - Run count == STUFF_LEN and the bit is opposite to the run value: it is a stuff bit. Drop it (no bitValid); run value = bit, count = 1.
  - Run count == STUFF_LEN and the bit equals the run value: pulse stuffErr, no bitValid, go to ERROR.
- RX, destuffEn = 0:
  - Pass every bit through with bitValid; the run counter is frozen.
  - Count consecutive recessive bits. Reaching IDLE_BITS -> WAIT_SOF (the end of frame plus intermission has been seen).
  - A dominant bit clears the recessive count.
- ERROR:
  - No bitValid is emitted.
  - Count consecutive recessive bits; a dominant bit clears the count.
  - Reaching IDLE_BITS -> WAIT_SOF.
- The run counter width is clog2(STUFF_LEN+1); the recessive counter width is clog2(IDLE_BITS+1). Neither counter wraps.
- destuffEn is sampled in the same cycle as the deciding sample.
- Reset mid-frame aborts immediately, with no trailing pulses.

Optional Feature:
- Macro: CAN_MULTISAMPLE_EN.
- With the macro and multiSelect = 1:
  - Samples are accumulated per bit period: up to 3, with bit value = majority of the 3.
  - The bit is decided on the 3rd samplePulse, or on the next canClk rising edge if fewer than 3 samples arrived.
  - With 1 sample, the bit is that sample. With 2 disagreeing samples, the bit is dominant (0).
  - If a canClk rise and a samplePulse occur in the same cycle, commit the pending bit first, then the sample opens the new accumulation.
  - Latency is 1 clk from the deciding event.
- With the macro and multiSelect = 0: behaviour as without the macro.
- Without the macro: the multiSelect port exists but is unused; no accumulation logic is built.

Decomposition:
- Package can_rx_pkg holds:
  - the state enum {INTEGRATE, WAIT_SOF, RX, ERROR};
  - the constants RECESSIVE = 1'b1 and DOMINANT = 1'b0.
- Sub-module can_majority3: the sample accumulator and voter with canClk edge detect. It is instantiated only under CAN_MULTISAMPLE_EN.

Test Plan:
1. Reset, then 11 recessive bits -> busIdle rises 1 clk after the 11th samplePulse. Only 10 recessive bits then a dominant -> busIdle stays 0.
2. Idle, then bits 0,1,1,0,1 -> sofPulse together with the first bitValid; 5 bitValid strobes with bitOut = 0,1,1,0,1.
3. In RX, bits 0,0,0,0,0,1(stuff),0 -> exactly 6 bitValid strobes (the SOF bit plus 5 zeros... data as sent, with the stuff 1 dropped); run resets so the following 0 is valid.
4. In RX, 5 zeros then a 6th 0 -> stuffErr pulses 1 clk later and no bitValid for it. Then 11 recessive bits -> busIdle = 1.
5. destuffEn = 0, then 6 identical recessive bits -> all 6 pass with bitValid and no stuffErr. After 11 recessive bits total -> WAIT_SOF.
6. (CAN_MULTISAMPLE_EN, multiSelect = 1) samples 1,0,0 -> bitOut = 0. Samples 1,0 then a canClk rise -> bitOut = 0. Assert reset mid-accumulation -> no bitValid, all outputs 0.

Source files
------------

// File: rtl/can_rx_pkg.sv
// Shared types and bus-level constants for the CAN receive bit path.
package can_rx_pkg;

    typedef enum logic [1:0] {
        INTEGRATE,
        WAIT_SOF,
        RX,
        ERROR
    } rx_state_e;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/can_majority3.sv
// Triple-sample accumulator: votes on the 3rd sample, or commits a partial
// accumulation at the next bit-clock rise (two disagreeing samples -> dominant).
module can_majority3
    import can_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic can_clk,
    input  logic sample_bit,
    input  logic sample_pulse,
    output logic dec_valid,
    output logic dec_bit
);

    logic       can_clk_q, can_clk_d;
    logic [1:0] cnt_q, cnt_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       can_rise;

    assign can_rise = can_clk & ~can_clk_q;

    always_comb begin
        can_clk_d = can_clk;
        cnt_d     = cnt_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        dec_valid = 1'b0;
        dec_bit   = RECESSIVE;
        if (!en) begin
            cnt_d = '0;
        end else begin
            // A boundary commits the pending bit before a coincident sample opens the next one.
            if (can_rise && cnt_q != 2'd0) begin
                dec_valid = 1'b1;
                dec_bit   = (cnt_q == 2'd1) ? s0_q : (s0_q & s1_q);
                cnt_d     = '0;
            end
            if (sample_pulse) begin
                if (cnt_d == 2'd0) begin
                    s0_d  = sample_bit;
                    cnt_d = 2'd1;
                end else if (cnt_d == 2'd1) begin
                    s1_d  = sample_bit;
                    cnt_d = 2'd2;
                end else begin
                    dec_valid = 1'b1;
                    dec_bit   = majority3(s0_q, s1_q, sample_bit);
                    cnt_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            can_clk_q <= 1'b0;
            cnt_q     <= '0;
            s0_q      <= RECESSIVE;
            s1_q      <= RECESSIVE;
        end else begin
            can_clk_q <= can_clk_d;
            cnt_q     <= cnt_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
        end
    end

endmodule

// File: rtl/can_bit_destuffer.sv
// Bus integration, SOF detection, bit destuffing and stuff-error detection.
// Optional CAN_MULTISAMPLE_EN builds the three-sample majority decision path.
module can_bit_destuffer
    import can_rx_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned IDLE_BITS = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic canClk,
    input  logic sampleBit,
    input  logic samplePulse,
    input  logic multiSelect,
    input  logic destuffEn,
    output logic bitOut,
    output logic bitValid,
    output logic sofPulse,
    output logic stuffErr,
    output logic busIdle
);

    localparam int unsigned SW = $clog2(STUFF_LEN + 1);
    localparam int unsigned RW = $clog2(IDLE_BITS + 1);
    localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);
    localparam logic [RW-1:0] IDLE_LAST = RW'(IDLE_BITS - 1);

    logic dec_valid, dec_bit;

`ifdef CAN_MULTISAMPLE_EN
    logic maj_valid, maj_bit;

    can_majority3 u_majority3 (
        .clk          (clk),
        .rst          (reset),
        .en           (multiSelect),
        .can_clk      (canClk),
        .sample_bit   (sampleBit),
        .sample_pulse (samplePulse),
        .dec_valid    (maj_valid),
        .dec_bit      (maj_bit)
    );

    always_comb begin
        dec_valid = multiSelect ? maj_valid : samplePulse;
        dec_bit   = multiSelect ? maj_bit   : sampleBit;
    end
`else
    logic unused_inputs;

    always_comb begin
        dec_valid     = samplePulse;
        dec_bit       = sampleBit;
        unused_inputs = canClk ^ multiSelect;
    end
`endif

    rx_state_e   state_q, state_d;
    logic        run_val_q, run_val_d;
    logic [SW-1:0] run_cnt_q, run_cnt_d;
    logic [RW-1:0] rec_cnt_q, rec_cnt_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        sof_q, sof_d;
    logic        stuff_err_q, stuff_err_d;
    logic        bus_idle_q, bus_idle_d;
    logic        idle_reached;

    // Shared by INTEGRATE, ERROR and the unstuffed tail of RX.
    assign idle_reached = (dec_bit == RECESSIVE) && (rec_cnt_q == IDLE_LAST);

    always_comb begin
        state_d     = state_q;
        run_val_d   = run_val_q;
        run_cnt_d   = run_cnt_q;
        rec_cnt_d   = rec_cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        sof_d       = 1'b0;
        stuff_err_d = 1'b0;
        bus_idle_d  = bus_idle_q;

        if (dec_valid) begin
            case (state_q)
                INTEGRATE, ERROR: begin
                    if (idle_reached) begin
                        state_d    = WAIT_SOF;
                        bus_idle_d = 1'b1;
                        rec_cnt_d  = '0;
                    end else if (dec_bit == RECESSIVE) begin
                        rec_cnt_d = rec_cnt_q + 1'b1;
                    end else begin
                        rec_cnt_d = '0;
                    end
                end
                WAIT_SOF: begin
                    if (dec_bit == DOMINANT) begin
                        state_d     = RX;
                        bit_valid_d = 1'b1;
                        bit_out_d   = DOMINANT;
                        sof_d       = 1'b1;
                        bus_idle_d  = 1'b0;
                        run_val_d   = DOMINANT;
                        run_cnt_d   = SW'(1);
                        rec_cnt_d   = '0;
                    end
                end
                RX: begin
                    if (destuffEn) begin
                        rec_cnt_d = '0;
                        if (run_cnt_q < STUFF_MAX) begin
                            bit_valid_d = 1'b1;
                            bit_out_d   = dec_bit;
                            if (dec_bit == run_val_q) begin
                                run_cnt_d = run_cnt_q + 1'b1;
                            end else begin
                                run_val_d = dec_bit;
                                run_cnt_d = SW'(1);
                            end
                        end else if (dec_bit != run_val_q) begin
                            run_val_d = dec_bit;
                            run_cnt_d = SW'(1);
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = ERROR;
                        end
                    end else begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = dec_bit;
                        if (idle_reached) begin
                            state_d    = WAIT_SOF;
                            bus_idle_d = 1'b1;
                            rec_cnt_d  = '0;
                        end else if (dec_bit == RECESSIVE) begin
                            rec_cnt_d = rec_cnt_q + 1'b1;
                        end else begin
                            rec_cnt_d = '0;
                        end
                    end
                end
                default: state_d = INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INTEGRATE;
            run_val_q   <= RECESSIVE;
            run_cnt_q   <= '0;
            rec_cnt_q   <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            bus_idle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            sof_q       <= sof_d;
            stuff_err_q <= stuff_err_d;
            bus_idle_q  <= bus_idle_d;
        end
    end

    assign bitOut   = bit_out_q;
    assign bitValid = bit_valid_q;
    assign sofPulse = sof_q;
    assign stuffErr = stuff_err_q;
    assign busIdle  = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboard bench for can_bit_destuffer; the multi-sample scenario runs only
// when CAN_MULTISAMPLE_EN is defined.
module tb_can_bit_destuffer;

    logic clk = 1'b0;
    logic reset, canClk, sampleBit, samplePulse, multiSelect, destuffEn;
    logic bitOut, bitValid, sofPulse, stuffErr, busIdle;

    typedef struct packed {
        logic b;
        logic sof;
    } exp_t;

    exp_t sb[$];
    int checks     = 0;
    int failures   = 0;
    int valid_seen = 0;
    int stuff_seen = 0;

    can_bit_destuffer #(.STUFF_LEN(5), .IDLE_BITS(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .canClk      (canClk),
        .sampleBit   (sampleBit),
        .samplePulse (samplePulse),
        .multiSelect (multiSelect),
        .destuffEn   (destuffEn),
        .bitOut      (bitOut),
        .bitValid    (bitValid),
        .sofPulse    (sofPulse),
        .stuffErr    (stuffErr),
        .busIdle     (busIdle)
    );

    always #5 clk = ~clk;

    // Output monitor: every bitValid must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bitValid === 1'b1) begin
                valid_seen++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid got bitOut=%b sof=%b expected no strobe", bitOut, sofPulse);
                end else begin
                    e = sb.pop_front();
                    if (bitOut !== e.b || sofPulse !== e.sof) begin
                        failures++;
                        $display("FAIL bit_compare got bitOut=%b sof=%b expected bitOut=%b sof=%b",
                                 bitOut, sofPulse, e.b, e.sof);
                    end
                end
            end else if (sofPulse !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL sof_without_valid got sofPulse=%b expected 0", sofPulse);
            end
            if (stuffErr === 1'b1) stuff_seen++;
        end
    end

    task automatic send_bit(input logic b, input logic push, input logic sof);
        @(negedge clk);
        canClk = 1'b1;
        @(negedge clk);
        canClk      = 1'b0;
        sampleBit   = b;
        samplePulse = 1'b1;
        if (push) sb.push_back(exp_t'({b, sof}));
        @(negedge clk);
        samplePulse = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        canClk      = 1'b0;
        sampleBit   = 1'b1;
        samplePulse = 1'b0;
        destuffEn   = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic go_idle();
        do_reset();
        repeat (11) send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bitValid, bitOut, sofPulse, stuffErr, busIdle} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 00000",
                     {bitValid, bitOut, sofPulse, stuffErr, busIdle});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_integrate();
        do_reset();
        repeat (10) send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL idle_after_10 got %b expected 0", busIdle); end
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL idle_after_dominant got %b expected 0", busIdle); end
        repeat (10) send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL idle_restart_10 got %b expected 0", busIdle); end
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b1) begin failures++; $display("FAIL idle_after_11 got %b expected 1", busIdle); end
    endtask

    task automatic test_sof();
        int v0;
        logic [4:0] pat;
        v0  = valid_seen;
        pat = 5'b10110;
        for (int i = 0; i < 5; i++) send_bit(pat[i], 1'b1, (i == 0));
        repeat (2) @(negedge clk);
        checks++;
        if (valid_seen - v0 !== 5) begin failures++; $display("FAIL sof_frame_count got %0d expected 5", valid_seen - v0); end
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL sof_idle_drop got %b expected 0", busIdle); end
    endtask

    task automatic test_destuff();
        int v0, s0;
        go_idle();
        v0 = valid_seen;
        s0 = stuff_seen;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, (i == 0));
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (valid_seen - v0 !== 6) begin failures++; $display("FAIL destuff_count got %0d expected 6", valid_seen - v0); end
        checks++;
        if (stuff_seen != s0) begin failures++; $display("FAIL destuff_no_err got %0d expected 0", stuff_seen - s0); end
    endtask

    task automatic test_stuff_error();
        int s0;
        go_idle();
        s0 = stuff_seen;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, (i == 0));
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (stuffErr !== 1'b1 || bitValid !== 1'b0) begin
            failures++;
            $display("FAIL stuff_err_pulse got err=%b valid=%b expected err=1 valid=0", stuffErr, bitValid);
        end
        repeat (10) send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL err_idle_10 got %b expected 0", busIdle); end
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (busIdle !== 1'b1) begin failures++; $display("FAIL err_idle_11 got %b expected 1", busIdle); end
        checks++;
        if (stuff_seen - s0 !== 1) begin failures++; $display("FAIL stuff_err_count got %0d expected 1", stuff_seen - s0); end
    endtask

    task automatic test_destuff_off();
        int s0;
        go_idle();
        s0 = stuff_seen;
        send_bit(1'b0, 1'b1, 1'b1);
        destuffEn = 1'b0;
        repeat (6) send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (busIdle !== 1'b0) begin failures++; $display("FAIL off_idle_6 got %b expected 0", busIdle); end
        repeat (5) send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (busIdle !== 1'b1) begin failures++; $display("FAIL off_idle_11 got %b expected 1", busIdle); end
        checks++;
        if (stuff_seen != s0) begin failures++; $display("FAIL off_no_err got %0d expected 0", stuff_seen - s0); end
        destuffEn = 1'b1;
        send_bit(1'b0, 1'b1, 1'b1);
        checks++;
        if (sofPulse !== 1'b1) begin failures++; $display("FAIL off_next_sof got %b expected 1", sofPulse); end
    endtask

    task automatic test_back_to_back();
        int   v0, s0, n_data, run_n;
        logic run_v, b;
        go_idle();
        v0 = valid_seen;
        s0 = stuff_seen;
        send_bit(1'b0, 1'b1, 1'b1);
        run_v  = 1'b0;
        run_n  = 1;
        n_data = 40;
        for (int i = 0; i < n_data; i++) begin
            if (run_n == 5) begin
                send_bit(~run_v, 1'b0, 1'b0);
                run_v = ~run_v;
                run_n = 1;
            end
            b = ($urandom_range(0, 3) != 0) ? run_v : ~run_v;
            send_bit(b, 1'b1, 1'b0);
            if (b == run_v) run_n++;
            else begin
                run_v = b;
                run_n = 1;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (valid_seen - v0 !== n_data + 1) begin
            failures++;
            $display("FAIL b2b_count got %0d expected %0d", valid_seen - v0, n_data + 1);
        end
        checks++;
        if (stuff_seen != s0 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_clean got errs=%0d pending=%0d expected 0 0", stuff_seen - s0, sb.size());
        end
    endtask

    task automatic test_reset_midframe();
        go_idle();
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        sampleBit   = 1'b0;
        samplePulse = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        samplePulse = 1'b0;
        checks++;
        if ({bitValid, bitOut, sofPulse, stuffErr, busIdle} !== 5'b0) begin
            failures++;
            $display("FAIL midframe_reset got %b expected 00000",
                     {bitValid, bitOut, sofPulse, stuffErr, busIdle});
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL midframe_pending got %0d expected 0", sb.size()); end
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef CAN_MULTISAMPLE_EN
    task automatic ms_sample(input logic b);
        @(negedge clk);
        sampleBit   = b;
        samplePulse = 1'b1;
        @(negedge clk);
        samplePulse = 1'b0;
    endtask

    task automatic ms_rise();
        @(negedge clk);
        canClk = 1'b1;
        @(negedge clk);
        canClk = 1'b0;
    endtask

    task automatic test_multisample();
        int v0;
        go_idle();
        multiSelect = 1'b1;
        v0 = valid_seen;
        ms_rise();
        ms_sample(1'b0);
        ms_sample(1'b0);
        sb.push_back(exp_t'({1'b0, 1'b1}));
        ms_sample(1'b0);
        ms_rise();
        ms_sample(1'b1);
        ms_sample(1'b0);
        sb.push_back(exp_t'({1'b0, 1'b0}));
        ms_sample(1'b0);
        ms_rise();
        ms_sample(1'b1);
        ms_sample(1'b0);
        sb.push_back(exp_t'({1'b0, 1'b0}));
        ms_rise();
        ms_sample(1'b1);
        sb.push_back(exp_t'({1'b1, 1'b0}));
        ms_rise();
        ms_sample(1'b0);
        sb.push_back(exp_t'({1'b0, 1'b0}));
        @(negedge clk);
        canClk      = 1'b1;
        sampleBit   = 1'b1;
        samplePulse = 1'b1;
        @(negedge clk);
        canClk      = 1'b0;
        samplePulse = 1'b0;
        sb.push_back(exp_t'({1'b1, 1'b0}));
        ms_rise();
        repeat (2) @(negedge clk);
        checks++;
        if (valid_seen - v0 !== 6) begin failures++; $display("FAIL ms_count got %0d expected 6", valid_seen - v0); end
        ms_sample(1'b0);
        reset = 1'b1;
        ms_rise();
        checks++;
        if ({bitValid, bitOut, sofPulse, stuffErr, busIdle} !== 5'b0) begin
            failures++;
            $display("FAIL ms_reset got %b expected 00000", {bitValid, bitOut, sofPulse, stuffErr, busIdle});
        end
        reset = 1'b0;
        v0 = valid_seen;
        ms_rise();
        repeat (2) @(negedge clk);
        checks++;
        if (valid_seen != v0) begin failures++; $display("FAIL ms_reset_flush got %0d expected 0", valid_seen - v0); end
        multiSelect = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        canClk      = 1'b0;
        sampleBit   = 1'b1;
        samplePulse = 1'b0;
        multiSelect = 1'b0;
        destuffEn   = 1'b1;
        test_reset();
        test_integrate();
        test_sof();
        test_destuff();
        test_stuff_error();
        test_destuff_off();
        test_back_to_back();
        test_reset_midframe();
`ifdef CAN_MULTISAMPLE_EN
        test_multisample();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_pending got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
